// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard, flush, forwarding and memory-freeze controller for the 5-stage ARM pipeline
//
// Ports:
//   CLK, CLR                 clock; asynchronous active-high reset
//   ID_Rn/Rm/Rd, ID_use_*    source registers of the ID instruction and whether each is read
//   EX/MEM/WB_Rd, *_RF_enable destination register and write enable per downstream stage
//   EX_Load_Inst             instruction in EX is a load
//   branch_taken             branch in ID resolved taken
//   MEM_enable, DMEM_ready   data-memory access request / completion
//   PC_LE, IFID_LE           PC and IF/ID load enables
//   CU_mux_sel               inject a NOP into ID/EX
//   IFID_flush               synchronous clear of IF/ID
//   PIPE_FREEZE              hold ID/EX, EX/MEM, MEM/WB
//   FWD_A/B/C                forward select for Rn/Rm/Rd: 00 RF, 01 EX, 10 MEM, 11 WB
//   mem_error                sticky memory timeout flag
//   stall_cnt, flush_cnt     statistics counters
//
// Optional feature macro: HAZARD_STATS_EN (saturating stall/flush counters; tied to 0 when undefined)

module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [3:0]       ID_Rn,
    input  logic [3:0]       ID_Rm,
    input  logic [3:0]       ID_Rd,
    input  logic             ID_use_Rn,
    input  logic             ID_use_Rm,
    input  logic             ID_use_Rd,
    input  logic [3:0]       EX_Rd,
    input  logic [3:0]       MEM_Rd,
    input  logic [3:0]       WB_Rd,
    input  logic             EX_RF_enable,
    input  logic             MEM_RF_enable,
    input  logic             WB_RF_enable,
    input  logic             EX_Load_Inst,
    input  logic             branch_taken,
    input  logic             MEM_enable,
    input  logic             DMEM_ready,
    output logic             PC_LE,
    output logic             IFID_LE,
    output logic             CU_mux_sel,
    output logic             IFID_flush,
    output logic             PIPE_FREEZE,
    output logic [1:0]       FWD_A,
    output logic [1:0]       FWD_B,
    output logic [1:0]       FWD_C,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERROR    = 2'd2;

    localparam logic [7:0] TIMEOUT_V = 8'(MEM_TIMEOUT);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    logic       mem_wait;
    logic       frozen;
    logic       load_use;
    logic       ex_can_fwd;

    assign mem_wait = MEM_enable & ~DMEM_ready;

    // In MEM_WAIT the freeze persists on !DMEM_ready alone, so a request
    // that drops MEM_enable before completing still keeps the pipe held.
    assign frozen = ((state == ST_RUN) & mem_wait)
                  | ((state == ST_MEM_WAIT) & ~DMEM_ready)
                  | (state == ST_ERROR);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_RUN: begin
                if (mem_wait) begin
                    state_nxt    = ST_MEM_WAIT;
                    wait_cnt_nxt = 8'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (DMEM_ready) begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = 8'd0;
                end else if (wait_cnt == TIMEOUT_V) begin
                    state_nxt = ST_ERROR;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            ST_ERROR: begin
                state_nxt = ST_ERROR;
            end
            default: begin
                state_nxt    = ST_RUN;
                wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state    <= ST_RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    assign mem_error = (state == ST_ERROR);

    // R15 is the PC, never a real RF producer, so it never creates a hazard.
    assign load_use = EX_Load_Inst & EX_RF_enable & (EX_Rd != 4'd15)
                    & ((ID_use_Rn & (ID_Rn == EX_Rd))
                     | (ID_use_Rm & (ID_Rm == EX_Rd))
                     | (ID_use_Rd & (ID_Rd == EX_Rd)));

    always_comb begin
        PC_LE       = 1'b1;
        IFID_LE     = 1'b1;
        CU_mux_sel  = 1'b0;
        IFID_flush  = 1'b0;
        PIPE_FREEZE = 1'b0;
        if (frozen) begin
            PIPE_FREEZE = 1'b1;
            PC_LE       = 1'b0;
            IFID_LE     = 1'b0;
        end else if (load_use) begin
            PC_LE      = 1'b0;
            IFID_LE    = 1'b0;
            CU_mux_sel = 1'b1;
        end else if (branch_taken) begin
            IFID_flush = 1'b1;
        end
    end

    // A load in EX has no data yet; its value is forwarded from MEM once the
    // bubble has pushed it one stage further.
    assign ex_can_fwd = EX_RF_enable & ~EX_Load_Inst;

    function automatic logic [1:0] fwd_sel(input logic [3:0] src, input logic used);
        logic [1:0] sel;
        sel = 2'b00;
        if (used && (src != 4'd15)) begin
            if (ex_can_fwd && (EX_Rd == src)) begin
                sel = 2'b01;
            end else if (MEM_RF_enable && (MEM_Rd == src)) begin
                sel = 2'b10;
            end else if (WB_RF_enable && (WB_Rd == src)) begin
                sel = 2'b11;
            end
        end
        return sel;
    endfunction

    assign FWD_A = fwd_sel(ID_Rn, ID_use_Rn);
    assign FWD_B = fwd_sel(ID_Rm, ID_use_Rm);
    assign FWD_C = fwd_sel(ID_Rd, ID_use_Rd);

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!PC_LE && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (IFID_flush && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl

module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 16;
`ifdef HAZARD_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             CLR;
    logic [3:0]       ID_Rn, ID_Rm, ID_Rd, EX_Rd, MEM_Rd, WB_Rd;
    logic             ID_use_Rn, ID_use_Rm, ID_use_Rd;
    logic             EX_RF_enable, MEM_RF_enable, WB_RF_enable;
    logic             EX_Load_Inst, branch_taken, MEM_enable, DMEM_ready;
    logic             PC_LE, IFID_LE, CU_mux_sel, IFID_flush, PIPE_FREEZE, mem_error;
    logic [1:0]       FWD_A, FWD_B, FWD_C;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: consecutive frozen cycles, sticky error, stats.
    int m_waits   = 0;
    bit m_err     = 1'b0;
    int m_stalls  = 0;
    int m_flushes = 0;

    logic [11:0] obs;
    assign obs = {PC_LE, IFID_LE, CU_mux_sel, IFID_flush, PIPE_FREEZE,
                  FWD_A, FWD_B, FWD_C, mem_error};

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .CLR(CLR),
        .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
        .ID_use_Rn(ID_use_Rn), .ID_use_Rm(ID_use_Rm), .ID_use_Rd(ID_use_Rd),
        .EX_Rd(EX_Rd), .MEM_Rd(MEM_Rd), .WB_Rd(WB_Rd),
        .EX_RF_enable(EX_RF_enable), .MEM_RF_enable(MEM_RF_enable), .WB_RF_enable(WB_RF_enable),
        .EX_Load_Inst(EX_Load_Inst), .branch_taken(branch_taken),
        .MEM_enable(MEM_enable), .DMEM_ready(DMEM_ready),
        .PC_LE(PC_LE), .IFID_LE(IFID_LE), .CU_mux_sel(CU_mux_sel), .IFID_flush(IFID_flush),
        .PIPE_FREEZE(PIPE_FREEZE), .FWD_A(FWD_A), .FWD_B(FWD_B), .FWD_C(FWD_C),
        .mem_error(mem_error), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic clear_inputs();
        ID_Rn = 4'd0; ID_Rm = 4'd0; ID_Rd = 4'd0;
        ID_use_Rn = 1'b0; ID_use_Rm = 1'b0; ID_use_Rd = 1'b0;
        EX_Rd = 4'd0; MEM_Rd = 4'd0; WB_Rd = 4'd0;
        EX_RF_enable = 1'b0; MEM_RF_enable = 1'b0; WB_RF_enable = 1'b0;
        EX_Load_Inst = 1'b0; branch_taken = 1'b0;
        MEM_enable = 1'b0; DMEM_ready = 1'b1;
    endtask

    // Leaves the bench just after a falling edge with CLR released.
    task automatic do_reset();
        clear_inputs();
        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        m_waits = 0; m_err = 1'b0; m_stalls = 0; m_flushes = 0;
    endtask

    // Youngest producer first; R15 and unread sources always come from RF.
    function automatic logic [1:0] ref_fwd(input logic [3:0] s, input logic used);
        if (!used || s == 4'd15) return 2'b00;
        if (EX_RF_enable && !EX_Load_Inst && EX_Rd == s) return 2'b01;
        if (MEM_RF_enable && MEM_Rd == s) return 2'b10;
        if (WB_RF_enable && WB_Rd == s) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [11:0] ref_outputs();
        bit frozen, hazard, pc, cu, fl;
        frozen = m_err || (!DMEM_ready && (MEM_enable || m_waits > 0));
        hazard = EX_Load_Inst && EX_RF_enable && EX_Rd != 4'd15 &&
                 ((ID_use_Rn && ID_Rn == EX_Rd) || (ID_use_Rm && ID_Rm == EX_Rd) ||
                  (ID_use_Rd && ID_Rd == EX_Rd));
        pc = !(frozen || hazard);
        cu = !frozen && hazard;
        fl = !frozen && !hazard && branch_taken;
        return {pc, pc, cu, fl, frozen, ref_fwd(ID_Rn, ID_use_Rn),
                ref_fwd(ID_Rm, ID_use_Rm), ref_fwd(ID_Rd, ID_use_Rd), m_err};
    endfunction

    task automatic model_tick(input logic [11:0] e);
        if (!m_err) begin
            if (e[7]) begin
                if (m_waits == MEM_TIMEOUT) m_err = 1'b1;
                else m_waits++;
            end else begin
                m_waits = 0;
            end
        end
        if (!e[11] && m_stalls < (1 << CNT_W) - 1) m_stalls++;
        if (e[8] && m_flushes < (1 << CNT_W) - 1) m_flushes++;
    endtask

    function automatic logic [3:0] rand_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'd15 : 4'(r);
    endfunction

    task automatic test_reset();
        clear_inputs();
        CLR = 1'b1;
        @(negedge CLK);
        #2;
        n_checks++;
        if (obs !== 12'b1100_0000_0000) begin
            n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, 12'b1100_0000_0000);
        end
        n_checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            n_fail++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        @(negedge CLK);
        CLR = 1'b0;
    endtask

    task automatic test_forward_ex();
        do_reset();
        EX_Rd = 4'd5; EX_RF_enable = 1'b1; ID_Rn = 4'd5; ID_use_Rn = 1'b1;
        #2;
        n_checks++;
        if ({FWD_A, PC_LE, CU_mux_sel} !== 4'b01_1_0) begin
            n_fail++; $display("FAIL fwd_ex: got FWD_A=%b PC_LE=%b CU=%b want 01 1 0", FWD_A, PC_LE, CU_mux_sel);
        end
        @(negedge CLK);
    endtask

    task automatic test_load_use();
        do_reset();
        EX_Rd = 4'd3; EX_RF_enable = 1'b1; EX_Load_Inst = 1'b1;
        ID_Rn = 4'd3; ID_use_Rn = 1'b1; ID_Rd = 4'd3;
        #2;
        n_checks++;
        if ({PC_LE, IFID_LE, CU_mux_sel, FWD_A} !== 5'b0_0_1_00) begin
            n_fail++; $display("FAIL load_use_stall: got %b want 00100", {PC_LE, IFID_LE, CU_mux_sel, FWD_A});
        end
        @(negedge CLK);
        // Bubble in EX, load now in MEM.
        EX_Rd = 4'd0; EX_RF_enable = 1'b0; EX_Load_Inst = 1'b0;
        MEM_Rd = 4'd3; MEM_RF_enable = 1'b1;
        #2;
        n_checks++;
        if ({PC_LE, IFID_LE, CU_mux_sel, FWD_A} !== 5'b1_1_0_10) begin
            n_fail++; $display("FAIL load_use_release: got %b want 11010", {PC_LE, IFID_LE, CU_mux_sel, FWD_A});
        end
        @(negedge CLK);
    endtask

    task automatic test_branch();
        do_reset();
        branch_taken = 1'b1;
        #2;
        n_checks++;
        if ({IFID_flush, PC_LE, IFID_LE, CU_mux_sel} !== 4'b1110) begin
            n_fail++; $display("FAIL branch_flush: got %b want 1110", {IFID_flush, PC_LE, IFID_LE, CU_mux_sel});
        end
        @(negedge CLK);
        branch_taken = 1'b0;
        #2;
        n_checks++;
        if (IFID_flush !== 1'b0 || flush_cnt !== (STATS_ON ? CNT_W'(1) : '0)) begin
            n_fail++; $display("FAIL branch_after: got flush=%b cnt=%0d want 0 %0d", IFID_flush, flush_cnt, STATS_ON ? 1 : 0);
        end
        @(negedge CLK);
    endtask

    task automatic test_branch_during_stall();
        do_reset();
        EX_Rd = 4'd7; EX_RF_enable = 1'b1; EX_Load_Inst = 1'b1;
        ID_Rm = 4'd7; ID_use_Rm = 1'b1; branch_taken = 1'b1;
        #2;
        n_checks++;
        if ({IFID_flush, CU_mux_sel, PC_LE} !== 3'b010) begin
            n_fail++; $display("FAIL branch_in_stall: got %b want 010", {IFID_flush, CU_mux_sel, PC_LE});
        end
        @(negedge CLK);
        EX_RF_enable = 1'b0; EX_Load_Inst = 1'b0; EX_Rd = 4'd0;
        #2;
        n_checks++;
        if ({IFID_flush, CU_mux_sel, PC_LE} !== 3'b101) begin
            n_fail++; $display("FAIL branch_after_stall: got %b want 101", {IFID_flush, CU_mux_sel, PC_LE});
        end
        @(negedge CLK);
    endtask

    task automatic test_mem_wait();
        do_reset();
        MEM_enable = 1'b1; DMEM_ready = 1'b0;
        // Freeze outranks a simultaneous load-use hazard and a taken branch.
        EX_Rd = 4'd2; EX_RF_enable = 1'b1; EX_Load_Inst = 1'b1;
        ID_Rn = 4'd2; ID_use_Rn = 1'b1; branch_taken = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            #2;
            n_checks++;
            if ({PIPE_FREEZE, PC_LE, IFID_LE, CU_mux_sel, IFID_flush} !== 5'b10000) begin
                n_fail++; $display("FAIL mem_wait_freeze%0d: got %b want 10000", k,
                                   {PIPE_FREEZE, PC_LE, IFID_LE, CU_mux_sel, IFID_flush});
            end
            @(negedge CLK);
        end
        clear_inputs();
        MEM_enable = 1'b1; DMEM_ready = 1'b1;
        #2;
        n_checks++;
        if ({PIPE_FREEZE, PC_LE} !== 2'b01) begin
            n_fail++; $display("FAIL mem_ready_release: got %b want 01", {PIPE_FREEZE, PC_LE});
        end
        @(negedge CLK);
        MEM_enable = 1'b0;
        #2;
        n_checks++;
        if (stall_cnt !== (STATS_ON ? CNT_W'(3) : '0) || PIPE_FREEZE !== 1'b0) begin
            n_fail++; $display("FAIL mem_wait_stats: got stall_cnt=%0d freeze=%b want %0d 0",
                               stall_cnt, PIPE_FREEZE, STATS_ON ? 3 : 0);
        end
        @(negedge CLK);
    endtask

    task automatic test_timeout();
        bit exp_err;
        do_reset();
        MEM_enable = 1'b1; DMEM_ready = 1'b0;
        for (int k = 1; k <= MEM_TIMEOUT + 3; k++) begin
            #2;
            exp_err = (k > MEM_TIMEOUT + 1);
            n_checks++;
            if ({PIPE_FREEZE, PC_LE, mem_error} !== {1'b1, 1'b0, exp_err}) begin
                n_fail++; $display("FAIL timeout_cycle%0d: got %b want %b", k,
                                   {PIPE_FREEZE, PC_LE, mem_error}, {1'b1, 1'b0, exp_err});
            end
            @(negedge CLK);
        end
        MEM_enable = 1'b0; DMEM_ready = 1'b1;
        #2;
        n_checks++;
        if ({PIPE_FREEZE, mem_error} !== 2'b11) begin
            n_fail++; $display("FAIL error_sticky: got %b want 11", {PIPE_FREEZE, mem_error});
        end
        clear_inputs();
        CLR = 1'b1;
        #1;
        n_checks++;
        if (obs !== 12'b1100_0000_0000) begin
            n_fail++; $display("FAIL error_clr: got %b want %b", obs, 12'b1100_0000_0000);
        end
        @(negedge CLK);
        CLR = 1'b0;
    endtask

    task automatic test_async_reset_mid_wait();
        do_reset();
        MEM_enable = 1'b1; DMEM_ready = 1'b0;
        @(negedge CLK);
        MEM_enable = 1'b0;
        #2;
        n_checks++;
        if (PIPE_FREEZE !== 1'b1) begin
            n_fail++; $display("FAIL wait_hold: got PIPE_FREEZE=%b want 1", PIPE_FREEZE);
        end
        CLR = 1'b1;
        #1;
        n_checks++;
        if ({PIPE_FREEZE, PC_LE, mem_error} !== 3'b010) begin
            n_fail++; $display("FAIL async_clr: got %b want 010", {PIPE_FREEZE, PC_LE, mem_error});
        end
        @(negedge CLK);
        CLR = 1'b0;
        DMEM_ready = 1'b1;
    endtask

    task automatic test_forward_priority();
        do_reset();
        MEM_Rd = 4'd5; MEM_RF_enable = 1'b1; WB_Rd = 4'd5; WB_RF_enable = 1'b1;
        ID_Rm = 4'd5; ID_use_Rm = 1'b1;
        EX_Rd = 4'd15; EX_RF_enable = 1'b1; ID_Rn = 4'd15; ID_use_Rn = 1'b1;
        ID_Rd = 4'd5; ID_use_Rd = 1'b0;
        #2;
        n_checks++;
        if ({FWD_A, FWD_B, FWD_C} !== 6'b00_10_00) begin
            n_fail++; $display("FAIL fwd_priority: got %b want 001000", {FWD_A, FWD_B, FWD_C});
        end
        @(negedge CLK);
        MEM_RF_enable = 1'b0; ID_use_Rd = 1'b1;
        #2;
        n_checks++;
        if ({FWD_B, FWD_C} !== 4'b11_11) begin
            n_fail++; $display("FAIL fwd_wb: got %b want 1111", {FWD_B, FWD_C});
        end
        @(negedge CLK);
    endtask

    task automatic test_random();
        logic [11:0]      e;
        logic [CNT_W-1:0] es, ef;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            ID_Rn = rand_reg(); ID_Rm = rand_reg(); ID_Rd = rand_reg();
            EX_Rd = rand_reg(); MEM_Rd = rand_reg(); WB_Rd = rand_reg();
            ID_use_Rn = 1'($urandom); ID_use_Rm = 1'($urandom); ID_use_Rd = 1'($urandom);
            EX_RF_enable = 1'($urandom); MEM_RF_enable = 1'($urandom); WB_RF_enable = 1'($urandom);
            EX_Load_Inst = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 3) == 0);
            MEM_enable   = ($urandom_range(0, 9) < 3);
            DMEM_ready   = ($urandom_range(0, 9) < 6);
            #2;
            e  = ref_outputs();
            es = STATS_ON ? CNT_W'(m_stalls) : '0;
            ef = STATS_ON ? CNT_W'(m_flushes) : '0;
            n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL random_outputs cycle %0d: got %b want %b", c, obs, e);
            end
            n_checks++;
            if (stall_cnt !== es || flush_cnt !== ef) begin
                n_fail++; $display("FAIL random_stats cycle %0d: got %0d/%0d want %0d/%0d",
                                   c, stall_cnt, flush_cnt, es, ef);
            end
            model_tick(e);
            if (m_err) do_reset();
            else @(negedge CLK);
        end
    endtask

    initial begin
        CLR = 1'b1;
        clear_inputs();
        test_reset();
        test_forward_ex();
        test_load_use();
        test_branch();
        test_branch_during_stall();
        test_mem_wait();
        test_timeout();
        test_async_reset_mid_wait();
        test_forward_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
